// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } nn_state_e;

  // Width of a beat counter that must hold the values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Zero negative values and clamp to the largest unsigned outW-bit value.
  // Works on a 64-bit signed value so layers with any ACC_W below 64 can reuse it.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] value, input int outW);
    logic signed [63:0] maxVal;
    maxVal = (64'sd1 <<< outW) - 64'sd1;
    if (value < 64'sd0) begin
      return 64'd0;
    end else if (value > maxVal) begin
      return maxVal;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/neuron_mac_relu_mac_unit.sv
// Combinational signed multiply, sign extension to accumulator width and add.
module mac_unit #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) (
  input  logic signed [DATA_W-1:0]   data_i,
  input  logic signed [WEIGHT_W-1:0] weight_i,
  input  logic signed [ACC_W-1:0]    addend_i,
  output logic signed [ACC_W-1:0]    sum_o
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  productExt;

  // Full-precision signed product, widened with its sign, then added; the add wraps at ACC_W.
  always_comb begin
    product    = data_i * weight_i;
    productExt = ACC_W'(product);
    sum_o      = addend_i + productExt;
  end

endmodule

// File: rtl/neuron_mac_relu.sv
// Serial MAC neuron: accumulates N_INPUTS weighted beats plus a bias, then
// presents a shifted, ReLU'd and saturated unsigned result on valid/ready.
module neuron_mac_relu
  import nn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 4,
  parameter int OUT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic signed [WEIGHT_W-1:0] in_weight,
  input  logic signed [ACC_W-1:0]    bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       busy
);

  localparam int CNT_W = cnt_width(N_INPUTS);

  nn_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    outValid_q, outValid_d;
  logic [OUT_W-1:0]        outData_q, outData_d;

  logic signed [ACC_W-1:0] macAddend;
  logic signed [ACC_W-1:0] macSum;
  logic signed [ACC_W-1:0] shiftedSum;
  logic [63:0]             satResult;
  logic                    beat;

  // The first beat of a vector starts from the bias; later beats from the running sum.
  always_comb begin
    macAddend = (state_q == IDLE) ? bias : acc_q;
  end

  mac_unit #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .data_i   (in_data),
    .weight_i (in_weight),
    .addend_i (macAddend),
    .sum_o    (macSum)
  );

  // Result as it would be if the current beat were the last one of the vector.
  always_comb begin
    shiftedSum = macSum >>> SHIFT;
    satResult  = relu_sat(64'(shiftedSum), OUT_W);
  end

  // Next-state logic: accept beats until the vector is complete, then hold the result.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    beat       = in_valid && (state_q != OUTPUT);

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = macSum;
          count_d = CNT_W'(1);
          if (N_INPUTS == 1) begin
            state_d    = OUTPUT;
            outValid_d = 1'b1;
            outData_d  = OUT_W'(satResult);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d   = macSum;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_INPUTS - 1)) begin
            state_d    = OUTPUT;
            outValid_d = 1'b1;
            outData_d  = OUT_W'(satResult);
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d    = IDLE;
          outValid_d = 1'b0;
          count_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and output registers; reset discards any partial or pending work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  // Handshake outputs depend only on registered state.
  always_comb begin
    in_ready  = (state_q != OUTPUT);
    busy      = (state_q != IDLE);
    out_valid = outValid_q;
    out_data  = outData_q;
  end

endmodule

// File: tb/tb_neuron_mac_relu.sv
// Self-checking bench: two neurons (SHIFT=0 and SHIFT=4) share one stimulus stream
// and are compared against an arithmetic model of the weighted sum.
module tb_neuron_mac_relu;

  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int N        = 4;
  localparam int ACC_W    = 24;
  localparam int OUT_W    = 8;

  typedef int vec_t[N];

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic signed [DATA_W-1:0]   in_data;
  logic signed [WEIGHT_W-1:0] in_weight;
  logic signed [ACC_W-1:0]    bias;
  logic                       out_ready;

  logic             inReady0, outValid0, busy0;
  logic             inReady4, outValid4, busy4;
  logic [OUT_W-1:0] outData0, outData4;

  int checks = 0;
  int errors = 0;

  neuron_mac_relu #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .N_INPUTS(N),
    .ACC_W(ACC_W), .SHIFT(0), .OUT_W(OUT_W)
  ) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady0),
    .in_data(in_data), .in_weight(in_weight), .bias(bias),
    .out_valid(outValid0), .out_ready(out_ready), .out_data(outData0), .busy(busy0)
  );

  neuron_mac_relu #(
    .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .N_INPUTS(N),
    .ACC_W(ACC_W), .SHIFT(4), .OUT_W(OUT_W)
  ) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady4),
    .in_data(in_data), .in_weight(in_weight), .bias(bias),
    .out_valid(outValid4), .out_ready(out_ready), .out_data(outData4), .busy(busy4)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: arithmetic shift, clamp negatives to 0 and large values to 255.
  function automatic longint modelOut(input longint sum, input int sh);
    longint v;
    v = sum >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_inReady0"}, 64'(inReady0), 1);
    checkOutput({tag, "_inReady4"}, 64'(inReady4), 1);
    checkOutput({tag, "_outValid0"}, 64'(outValid0), 0);
    checkOutput({tag, "_outValid4"}, 64'(outValid4), 0);
    checkOutput({tag, "_busy0"}, 64'(busy0), 0);
    checkOutput({tag, "_busy4"}, 64'(busy4), 0);
  endtask

  // Send one vector with random idle gaps; bias is only meaningful on the first beat.
  // Called and returns positioned just after a falling edge.
  task automatic applyStimulus(input string tag, input vec_t d, input vec_t w,
                               input longint b, input int maxGap, output longint sum);
    sum = b;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(maxGap)) begin
        in_valid  = 1'b0;
        in_data   = DATA_W'($urandom);
        in_weight = WEIGHT_W'($urandom);
        bias      = ACC_W'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      checkOutput({tag, "_beatReady"}, 64'(inReady0 & inReady4), 1);
      in_valid  = 1'b1;
      in_data   = DATA_W'(d[i]);
      in_weight = WEIGHT_W'(w[i]);
      bias      = (i == 0) ? ACC_W'(b) : ACC_W'($urandom);
      sum       = sum + longint'(d[i]) * longint'(w[i]);
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
    end
    checkOutput({tag, "_outValid0"}, 64'(outValid0), 1);
    checkOutput({tag, "_outValid4"}, 64'(outValid4), 1);
    checkOutput({tag, "_outData0"}, 64'(outData0), modelOut(sum, 0));
    checkOutput({tag, "_outData4"}, 64'(outData4), modelOut(sum, 4));
    checkOutput({tag, "_inReadyLow"}, 64'(inReady0 | inReady4), 0);
    checkOutput({tag, "_busy"}, 64'(busy0 & busy4), 1);
  endtask

  // Hold off the result for some cycles while offering junk beats, then take it.
  task automatic drainOutput(input string tag, input int hold, input longint sum);
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DATA_W'($urandom);
      in_weight = WEIGHT_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_holdValid"}, 64'(outValid0 & outValid4), 1);
      checkOutput({tag, "_holdData0"}, 64'(outData0), modelOut(sum, 0));
      checkOutput({tag, "_holdData4"}, 64'(outData4), modelOut(sum, 4));
      checkOutput({tag, "_holdReady"}, 64'(inReady0 | inReady4), 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdle({tag, "_drained"});
  endtask

  initial begin
    longint sum;
    vec_t d, w;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    bias      = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_outData0", 64'(outData0), 0);
    checkOutput("reset_outData4", 64'(outData4), 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain sum: 100, result taken immediately so in_ready is low for one cycle.
    d = '{10, 20, 30, 40}; w = '{1, 1, 1, 1};
    applyStimulus("sum100", d, w, 0, 0, sum);
    checkOutput("sum100_model", sum, 100);
    drainOutput("sum100", 0, sum);

    // Negative sum clamps to zero.
    d = '{10, 0, 0, 0}; w = '{2, int'($urandom_range(255)) - 128, -7, 99};
    applyStimulus("relu", d, w, -50, 1, sum);
    drainOutput("relu", 0, sum);

    // Large positive and large negative sums.
    d = '{127, 127, 127, 127}; w = '{127, 127, 127, 127};
    applyStimulus("satHi", d, w, 0, 0, sum);
    drainOutput("satHi", 0, sum);
    w = '{-128, -128, -128, -128};
    applyStimulus("satLo", d, w, 0, 0, sum);
    drainOutput("satLo", 0, sum);

    // 64 >>> 4 = 4 on the shifting neuron.
    d = '{16, 16, 16, 16}; w = '{1, 1, 1, 1};
    applyStimulus("shift", d, w, 0, 0, sum);
    drainOutput("shift", 0, sum);

    // Backpressure for five cycles, then the next vector must still be correct.
    d = '{10, 20, 30, 40}; w = '{1, 1, 1, 1};
    applyStimulus("bp", d, w, 0, 0, sum);
    drainOutput("bp", 5, sum);
    d = '{3, -5, 7, 9}; w = '{11, 13, -17, 19};
    applyStimulus("afterBp", d, w, 1000, 0, sum);
    drainOutput("afterBp", 0, sum);

    // Reset mid-vector, after two beats.
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'sd100;
      in_weight = 8'sd100;
      bias      = 24'sd5000;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkIdle("rstMid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset while a result is pending.
    d = '{50, 50, 50, 50}; w = '{50, 50, 50, 50};
    applyStimulus("pending", d, w, 0, 0, sum);
    reset = 1'b1;
    #1;
    checkIdle("rstPend");
    checkOutput("rstPend_outData0", 64'(outData0), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    d = '{1, 2, 3, 4}; w = '{1, 1, 1, 1};
    applyStimulus("postRst", d, w, 0, 0, sum);
    checkOutput("postRst_model", sum, 10);
    drainOutput("postRst", 0, sum);

    // Randomized vectors with random gaps, biases and backpressure.
    for (int v = 0; v < 25; v++) begin
      longint b;
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(255)) - 128;
        w[i] = int'($urandom_range(255)) - 128;
      end
      b = longint'($urandom_range(131072)) - 65536;
      applyStimulus("rand", d, w, b, 2, sum);
      drainOutput("rand", int'($urandom_range(3)), sum);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
